// File: rtl/axi4_slave_mem_pkg.sv
// rtl/axi4_slave_mem_pkg.sv - shared encodings and constants for the AXI4 slave write path
package axi4_slave_mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 2000001;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DATA  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Bursts the slave refuses to write: bad wrap length, reserved burst, or beats wider than the bus.
    function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len,
                                           input logic [2:0] size);
        logic bad_wrap_len;
        bad_wrap_len = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return ((burst == BURST_WRAP) && bad_wrap_len) || (burst == BURST_RSVD) || (size > 3'd2);
    endfunction

    function automatic logic [1:0] resp_encode(input logic decerr, input logic slverr);
        if (decerr) begin
            return RESP_DECERR;
        end else if (slverr) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_slave_mem_write_ctrl_if.sv
// rtl/axi4_slave_mem_write_ctrl_if.sv - AXI4 write channels (AW, W, B) bundled for the slave controller
interface axi4_slave_mem_write_ctrl_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_slave_addr_gen.sv
// rtl/axi4_slave_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi4_slave_addr_gen
    import axi4_slave_mem_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);
    logic [31:0] beat_bytes;
    logic [31:0] wrap_mask;
    logic [31:0] incr_addr;

    always_comb begin
        beat_bytes = 32'd1 << size;
        wrap_mask  = (({24'd0, len} + 32'd1) << size) - 32'd1;
        // An unaligned first beat snaps to the beat size before stepping.
        incr_addr  = (addr & ~(beat_bytes - 32'd1)) + beat_bytes;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = addr;
        endcase
    end
endmodule

// File: rtl/axi4_slave_mem_write_ctrl.sv
// rtl/axi4_slave_mem_write_ctrl.sv - AXI4 write slave that serialises each 32-bit beat into byte writes
module axi4_slave_mem_write_ctrl
    import axi4_slave_mem_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    axi4_slave_mem_write_ctrl_if.slave   axi,
    output logic [31:0]                  sys_addr,
    output logic [7:0]                   sys_wdata,
    output logic [31:0]                  sys_sel,
    output logic                         sys_wen,
    output logic                         sys_ren
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t          state_q, state_d;
    logic [ID_W-1:0] awid_q, awid_d;
    logic [31:0]     beat_addr_q, beat_addr_d;
    logic [7:0]      awlen_q, awlen_d;
    logic [2:0]      awsize_q, awsize_d;
    logic [1:0]      awburst_q, awburst_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [1:0]      lane_q, lane_d;
    logic            suppress_q, suppress_d;
    logic            slverr_q, slverr_d;
    logic            decerr_q, decerr_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [31:0]     sys_addr_q, sys_addr_d;
    logic [7:0]      sys_wdata_q, sys_wdata_d;
    logic [31:0]     sys_sel_q, sys_sel_d;
    logic            sys_wen_q, sys_wen_d;

    logic [31:0]     next_beat_addr;
    logic [31:0]     byte_addr;
    logic            lane_wanted;

    axi4_slave_addr_gen u_addr_gen (
        .addr      (beat_addr_q),
        .size      (awsize_q),
        .len       (awlen_q),
        .burst     (awburst_q),
        .next_addr (next_beat_addr)
    );

    always_comb begin
        state_d     = state_q;
        awid_d      = awid_q;
        beat_addr_d = beat_addr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        beat_cnt_d  = beat_cnt_q;
        lane_d      = lane_q;
        suppress_d  = suppress_q;
        slverr_d    = slverr_q;
        decerr_d    = decerr_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        sys_addr_d  = sys_addr_q;
        sys_wdata_d = sys_wdata_q;
        sys_sel_d   = 32'd0;
        sys_wen_d   = 1'b0;
        byte_addr   = {beat_addr_q[31:2], lane_q};
        lane_wanted = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (axi.awvalid && awready_q) begin
                    awid_d      = axi.awid;
                    beat_addr_d = axi.awaddr;
                    awlen_d     = axi.awlen;
                    awsize_d    = axi.awsize;
                    awburst_d   = axi.awburst;
                    beat_cnt_d  = 8'd0;
                    suppress_d  = burst_illegal(axi.awburst, axi.awlen, axi.awsize);
                    slverr_d    = burst_illegal(axi.awburst, axi.awlen, axi.awsize);
                    decerr_d    = 1'b0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi.wvalid && wready_q) begin
                    wdata_d = axi.wdata;
                    wstrb_d = axi.wstrb;
                    lane_d  = 2'd0;
                    // Burst length is fixed by awlen; a misplaced wlast only flags the error.
                    if (axi.wlast != (beat_cnt_q == awlen_q)) begin
                        slverr_d = 1'b1;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (lane_q == 2'd3) begin
                    if (beat_cnt_q == awlen_q) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_cnt_d  = beat_cnt_q + 8'd1;
                        beat_addr_d = next_beat_addr;
                        state_d     = ST_DATA;
                    end
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            default: begin
                if (axi.bready && bvalid_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        awready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_DATA);
        bvalid_d  = (state_d == ST_RESP);

        // Byte outputs are registered, so they are computed for the lane about to be presented.
        if (state_d == ST_WRITE) begin
            byte_addr   = {beat_addr_q[31:2], lane_d};
            lane_wanted = wstrb_d[lane_d] && !suppress_q;
            sys_addr_d  = byte_addr;
            sys_wdata_d = wdata_d[{lane_d, 3'b000} +: 8];
            sys_sel_d   = 32'd1 << lane_d;
            sys_wen_d   = lane_wanted && (byte_addr < MEM_LIMIT);
            if (lane_wanted && (byte_addr >= MEM_LIMIT)) begin
                decerr_d = 1'b1;
            end
        end

        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            bid_d   = awid_q;
            bresp_d = resp_encode(decerr_d, slverr_d);
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            awid_q      <= '0;
            beat_addr_q <= 32'd0;
            awlen_q     <= 8'd0;
            awsize_q    <= 3'd0;
            awburst_q   <= 2'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            beat_cnt_q  <= 8'd0;
            lane_q      <= 2'd0;
            suppress_q  <= 1'b0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= 2'd0;
            sys_addr_q  <= 32'd0;
            sys_wdata_q <= 8'd0;
            sys_sel_q   <= 32'd0;
            sys_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            awid_q      <= awid_d;
            beat_addr_q <= beat_addr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            beat_cnt_q  <= beat_cnt_d;
            lane_q      <= lane_d;
            suppress_q  <= suppress_d;
            slverr_q    <= slverr_d;
            decerr_q    <= decerr_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            sys_addr_q  <= sys_addr_d;
            sys_wdata_q <= sys_wdata_d;
            sys_sel_q   <= sys_sel_d;
            sys_wen_q   <= sys_wen_d;
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;

    assign sys_addr  = sys_addr_q;
    assign sys_wdata = sys_wdata_q;
    assign sys_sel   = sys_sel_q;
    assign sys_wen   = sys_wen_q;
    assign sys_ren   = 1'b0;

endmodule
